stack_frames: RTL and testbench

- Parametrised successor to the single-frame operand stack: a WebAssembly operand stack with call-frame support.
- Adds DUP/SWAP, frame-relative local peek, and a frame stack of base pointers.
- FRAME_LEAVE is multi-cycle: it copies result values down to the frame base.
- Sits between the wasm decoder/ALU (issues ops, consumes tos/nos) and the call/return control unit.

---
 rtl/stack_frames_if.sv | 24 ++
 rtl/stack_frames.sv | 199 +++++++++++++++++++
 tb/tb_stack_frames.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stack_frames_if.sv
// Operand-stack port bundle: decoder/ALU drives ops (master), stack answers (slave).
interface stack_frames_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  parameter int FRAMES = 2
);
  localparam int FL_W = (FRAMES > 0) ? $clog2(FRAMES + 1) : 1;

  logic [2:0]        op;
  logic [WIDTH-1:0]  data;
  logic [ADDR_W-1:0] index;
  logic [WIDTH-1:0]  tos;
  logic [WIDTH-1:0]  nos;
  logic [WIDTH-1:0]  peek;
  logic [1:0]        status;
  logic [1:0]        error;
  logic              busy;
  logic [FL_W-1:0]   frame_level;

  modport master (output op, data, index,
                  input  tos, nos, peek, status, error, busy, frame_level);
  modport slave  (input  op, data, index,
                  output tos, nos, peek, status, error, busy, frame_level);
endinterface

// File: rtl/stack_frames.sv
// WebAssembly operand stack with call frames; FRAME_LEAVE copies results down to the frame base.
module stack_frames #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  parameter int FRAMES = 2
) (
  input logic           clk,
  input logic           reset,
  stack_frames_if.slave bus
);
  localparam int CAP  = 1 << ADDR_W;
  localparam int SP_W = ADDR_W + 1;
  localparam int FL_W = (FRAMES > 0) ? $clog2(FRAMES + 1) : 1;

  typedef logic [SP_W-1:0] ptr_t;
  typedef enum logic [2:0] {
    OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_DUP, OP_SWAP, OP_ENTER, OP_LEAVE
  } op_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNDER, ERR_OVER, ERR_FRAME} err_e;
  typedef enum logic {IDLE, COPY} state_e;

  localparam ptr_t            CAP_P  = SP_W'(CAP);
  localparam logic [FL_W-1:0] FL_MAX = FL_W'(FRAMES);

  logic [WIDTH-1:0] mem  [CAP];
  ptr_t             fstk [1 << FL_W];

  state_e           state, state_n;
  ptr_t             sp, sp_n, fp, fp_n;
  ptr_t             src, src_n, dst, dst_n, cnt, cnt_n;
  logic [FL_W-1:0]  lvl, lvl_n, lvl_m1;
  err_e             err, err_n;
  logic [WIDTH-1:0] peek_r, tos_w, nos_w;

  logic              we0, we1, fs_we;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [WIDTH-1:0]  wd0, wd1;

  ptr_t        avail, n, sp_m1, sp_m2, top_src;
  logic [SP_W:0] pidx;

  assign avail   = sp - fp;
  assign n       = bus.data[ADDR_W:0];
  assign sp_m1   = sp - ptr_t'(1);
  assign sp_m2   = sp - ptr_t'(2);
  assign top_src = sp - n;
  assign lvl_m1  = lvl - 1'b1;
  assign pidx    = {1'b0, fp} + {{(SP_W + 1 - ADDR_W){1'b0}}, bus.index};
  assign tos_w   = (sp == '0) ? '0 : mem[sp_m1[ADDR_W-1:0]];
  assign nos_w   = (sp < ptr_t'(2)) ? '0 : mem[sp_m2[ADDR_W-1:0]];

  always_comb begin
    state_n = state;
    sp_n    = sp;
    fp_n    = fp;
    lvl_n   = lvl;
    err_n   = err;
    src_n   = src;
    dst_n   = dst;
    cnt_n   = cnt;
    we0     = 1'b0;
    wa0     = '0;
    wd0     = '0;
    we1     = 1'b0;
    wa1     = '0;
    wd1     = '0;
    fs_we   = 1'b0;
    case (state)
      COPY: begin
        // Ascending copy with dst < src, so overlapping regions stay correct.
        we0   = 1'b1;
        wa0   = dst[ADDR_W-1:0];
        wd0   = mem[src[ADDR_W-1:0]];
        src_n = src + ptr_t'(1);
        dst_n = dst + ptr_t'(1);
        cnt_n = cnt - ptr_t'(1);
        if (cnt == ptr_t'(1)) begin
          sp_n    = dst + ptr_t'(1);
          fp_n    = fstk[lvl_m1];
          lvl_n   = lvl_m1;
          state_n = IDLE;
        end
      end
      default: begin
        case (op_e'(bus.op))
          OP_PUSH:
            if (sp == CAP_P) err_n = ERR_OVER;
            else begin
              err_n = ERR_NONE;
              we0   = 1'b1;
              wa0   = sp[ADDR_W-1:0];
              wd0   = bus.data;
              sp_n  = sp + ptr_t'(1);
            end
          OP_POP:
            if (avail == '0) err_n = ERR_UNDER;
            else begin
              err_n = ERR_NONE;
              sp_n  = sp_m1;
            end
          OP_REPLACE:
            if (avail == '0) err_n = ERR_UNDER;
            else begin
              err_n = ERR_NONE;
              we0   = 1'b1;
              wa0   = sp_m1[ADDR_W-1:0];
              wd0   = bus.data;
            end
          OP_DUP:
            if (avail == '0) err_n = ERR_UNDER;
            else if (sp == CAP_P) err_n = ERR_OVER;
            else begin
              err_n = ERR_NONE;
              we0   = 1'b1;
              wa0   = sp[ADDR_W-1:0];
              wd0   = tos_w;
              sp_n  = sp + ptr_t'(1);
            end
          OP_SWAP:
            if (avail < ptr_t'(2)) err_n = ERR_UNDER;
            else begin
              err_n = ERR_NONE;
              we0   = 1'b1;
              wa0   = sp_m1[ADDR_W-1:0];
              wd0   = nos_w;
              we1   = 1'b1;
              wa1   = sp_m2[ADDR_W-1:0];
              wd1   = tos_w;
            end
          OP_ENTER:
            if (lvl == FL_MAX) err_n = ERR_FRAME;
            else if (n > avail) err_n = ERR_UNDER;
            else begin
              err_n = ERR_NONE;
              fs_we = 1'b1;
              fp_n  = top_src;
              lvl_n = lvl + 1'b1;
            end
          OP_LEAVE:
            if (lvl == '0) err_n = ERR_FRAME;
            else if (n > avail) err_n = ERR_UNDER;
            else begin
              err_n = ERR_NONE;
              if (n == '0 || top_src == fp) begin
                sp_n  = fp + n;
                fp_n  = fstk[lvl_m1];
                lvl_n = lvl_m1;
              end else begin
                state_n = COPY;
                src_n   = top_src;
                dst_n   = fp;
                cnt_n   = n;
              end
            end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sp     <= '0;
      fp     <= '0;
      lvl    <= '0;
      err    <= ERR_NONE;
      src    <= '0;
      dst    <= '0;
      cnt    <= '0;
      peek_r <= '0;
    end else begin
      state  <= state_n;
      sp     <= sp_n;
      fp     <= fp_n;
      lvl    <= lvl_n;
      err    <= err_n;
      src    <= src_n;
      dst    <= dst_n;
      cnt    <= cnt_n;
      peek_r <= (pidx < {1'b0, sp}) ? mem[pidx[ADDR_W-1:0]] : '0;
    end
  end

  // Storage carries no reset; sp/fp/lvl gate every read.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
    if (fs_we) fstk[lvl] <= fp;
  end

  assign bus.tos         = tos_w;
  assign bus.nos         = nos_w;
  assign bus.peek        = peek_r;
  assign bus.status      = (sp == '0) ? 2'd1 : (sp == CAP_P) ? 2'd2 : 2'd0;
  assign bus.error       = err;
  assign bus.busy        = (state == COPY);
  assign bus.frame_level = lvl;
endmodule

// File: tb/tb_stack_frames.sv
// Scoreboard bench: a frame-aware array model queues expected outputs per cycle; a monitor checks them.
`timescale 1ns/1ps
module tb_stack_frames;
  localparam int CAP = 4;
  localparam int NFR = 2;
  localparam int NONE = 0, PUSH = 1, POP = 2, REPL = 3, DUP = 4, SWAP = 5, ENTER = 6, LEAVE = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_frames_if #(.WIDTH(8), .ADDR_W(2), .FRAMES(2)) bus ();
  stack_frames #(.WIDTH(8), .ADDR_W(2), .FRAMES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int tos, nos, peek, status, err, busy, lvl;
    bit nos_chk, pk_chk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model
  int m[CAP];
  int sp = 0, fp = 0, lvl = 0, err = 0;
  int fst[NFR];
  int left = 0, nsp = 0, nfp = 0;
  int vals[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply_op(input int o, input int d);
    int avail, n, t;
    avail = sp - fp;
    n = d % 8;
    case (o)
      PUSH:  if (sp == CAP) err = 2; else begin m[sp] = d; sp++; err = 0; end
      POP:   if (avail < 1) err = 1; else begin sp--; err = 0; end
      REPL:  if (avail < 1) err = 1; else begin m[sp-1] = d; err = 0; end
      DUP:   if (avail < 1) err = 1; else if (sp == CAP) err = 2;
             else begin m[sp] = m[sp-1]; sp++; err = 0; end
      SWAP:  if (avail < 2) err = 1;
             else begin t = m[sp-1]; m[sp-1] = m[sp-2]; m[sp-2] = t; err = 0; end
      ENTER: if (lvl == NFR) err = 3; else if (n > avail) err = 1;
             else begin fst[lvl] = fp; lvl++; fp = sp - n; err = 0; end
      LEAVE: if (lvl == 0) err = 3; else if (n > avail) err = 1;
             else begin
               err = 0;
               if (n == 0 || sp - n == fp) begin
                 sp = fp + n; fp = fst[lvl-1]; lvl--;
               end else begin
                 vals.delete();
                 for (int i = sp - n; i < sp; i++) vals.push_back(m[i]);
                 left = n; nsp = fp + n; nfp = fst[lvl-1];
               end
             end
      default: ;
    endcase
  endtask

  task automatic finish_leave();
    for (int i = 0; i < vals.size(); i++) m[fp + i] = vals[i];
    sp = nsp; fp = nfp; lvl--;
  endtask

  task automatic step(input int o, input int d, input int ix, input bit rstn);
    exp_t e;
    @(negedge clk);
    reset = rstn;
    bus.op = 3'(o);
    bus.data = 8'(d);
    bus.index = 2'(ix);
    if (!rstn) begin
      sp = 0; fp = 0; lvl = 0; err = 0; left = 0;
      e.peek = 0; e.pk_chk = 1'b1;
    end else begin
      e.pk_chk = (left == 0);
      e.peek = (fp + ix < sp) ? m[fp + ix] : 0;
      if (left > 0) begin
        left--;
        if (left == 0) finish_leave();
      end else apply_op(o, d & 255);
    end
    e.tos = (sp > 0) ? m[sp-1] : 0;
    e.nos = (sp > 1) ? m[sp-2] : 0;
    e.nos_chk = (left == 0);
    e.status = (sp == 0) ? 1 : (sp == CAP) ? 2 : 0;
    e.err = err;
    e.busy = (left > 0) ? 1 : 0;
    e.lvl = lvl;
    q.push_back(e);
  endtask

  task automatic op(input int o, input int d);
    step(o, d, 0, 1'b1);
  endtask

  task automatic rst();
    step(NONE, 0, 0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tos", int'(bus.tos), e.tos);
        if (e.nos_chk) chk("nos", int'(bus.nos), e.nos);
        if (e.pk_chk) chk("peek", int'(bus.peek), e.peek);
        chk("status", int'(bus.status), e.status);
        chk("error", int'(bus.error), e.err);
        chk("busy", int'(bus.busy), e.busy);
        chk("frame_level", int'(bus.frame_level), e.lvl);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: scoreboard queue depth %0d, required 0", q.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    int r, o, d;
    bus.op = '0; bus.data = '0; bus.index = '0;
    rst(); rst();
    op(NONE, 0); op(POP, 0);
    op(PUSH, 1); op(PUSH, 2); op(PUSH, 3); op(PUSH, 4);
    op(PUSH, 5); op(DUP, 0); op(NONE, 0);
    rst(); op(PUSH, 7); op(PUSH, 9); op(SWAP, 0); op(DUP, 0);
    rst(); op(SWAP, 0);
    rst(); op(PUSH, 10); op(PUSH, 20); op(PUSH, 30); op(ENTER, 1);
    step(NONE, 0, 0, 1'b1); step(NONE, 0, 0, 1'b1);
    op(POP, 0); op(POP, 0); op(ENTER, 0); op(ENTER, 0);
    rst(); op(PUSH, 10); op(ENTER, 0); op(PUSH, 30); op(PUSH, 40); op(PUSH, 50);
    op(LEAVE, 2); op(PUSH, 99); op(POP, 0); op(NONE, 0); op(POP, 0); op(POP, 0);
    rst(); op(PUSH, 10); op(ENTER, 0); op(PUSH, 30); op(PUSH, 40); op(PUSH, 50);
    op(LEAVE, 2); op(NONE, 0); rst(); rst(); op(NONE, 0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst();
        continue;
      end
      r = $urandom_range(0, 11);
      case (r)
        0:         o = NONE;
        1, 2, 3:   o = PUSH;
        4:         o = POP;
        5:         o = REPL;
        6:         o = DUP;
        7:         o = SWAP;
        8, 9:      o = ENTER;
        default:   o = LEAVE;
      endcase
      if (o == ENTER || o == LEAVE)
        d = ($urandom_range(0, 31) << 3) | ($urandom_range(0, 5) == 0 ? $urandom_range(3, 7) : $urandom_range(0, 2));
      else
        d = $urandom_range(0, 255);
      step(o, d, $urandom_range(0, 3), 1'b1);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
